biquad_coef_loader: RTL and testbench
=====================================

# biquad_coef_loader

Coefficient-side initiator for the biquad filter unit's parameter-write port (`param_in` / `param_target` / `write_param`). It accepts a byte-serial command stream and assembles signed coefficients into a five-entry shadow bank. On a commit command it bursts all five coefficients into the filter. The burst happens only while the filter is idle and sample starts are held off, so a computation never mixes old and new coefficients. It sits between the host/config byte link and each biquad instance.

## Interface
- `data_width`, 16, coefficient width; must be a multiple of 8, range 8..32; `NB = data_width/8` payload bytes per coefficient.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  command/payload byte.
- `in_valid`  in  1  byte present on `in_data`.
- `in_ready`  out  1  loader accepts byte; transfer occurs when `in_valid && in_ready`.
- `filter_ready`  in  1  biquad `ready` output.
- `hold`  out  1  high = sample sequencer must not assert biquad `start`.
- `param_out`  out  data_width  to biquad `param_in`.
- `param_target`  out  3  coefficient index: 0 b0, 1 b1, 2 b2, 3 a1, 4 a2.
- `write_param`  out  1  one-cycle write strobe.
- `err`  out  1  sticky error flag.

## Operation
- Header byte: bits[7:6] = cmd, bits[2:0] = idx, bits[5:3] ignored.
  - cmd 00 WRITE: followed by NB payload bytes, MSB first, loaded into `shadow[idx]`.
  - cmd 01 COMMIT: burst shadow[0..4] to the filter.
  - cmd 10 CLEAR: all shadow entries := 0.
  - cmd 11 CLRERR: `err` := 0.
- WRITE with idx > 4: payload bytes are still consumed; the shadow bank is unchanged; `err` := 1.
- The shadow entry is updated only after the last payload byte. A partially received coefficient never reaches the shadow bank.
- States:
  - IDLE: wait for a header. WRITE goes to PAYLOAD. COMMIT goes to HOLD. CLEAR and CLRERR complete in the header cycle and stay in IDLE.
  - PAYLOAD: byte counter runs 0..NB-1. Then go to IDLE, or to CHECK when the checksum is enabled.
  - HOLD: `hold` = 1. Wait for a cycle in which `hold` was already 1 in the previous cycle AND `filter_ready` = 1, then go to BURST.
  - BURST: counter k = 0..4. Each cycle drives `param_target` = k, `param_out` = shadow[k], `write_param` = 1. After k = 4, go to IDLE.
- `hold` is 1 in HOLD and BURST and 0 otherwise.
- `in_ready` is 1 only in IDLE, PAYLOAD and CHECK.
- The shadow bank persists across commits, so repeated COMMITs rewrite identical values.
- Reset mid-operation:
  - Any state returns to IDLE and the byte counter clears.
  - A partial frame is discarded.
  - Shadow bank := 0.
  - A burst in progress stops immediately; no further strobes are issued.

## Timing
- Reset values: `in_ready` 1, `hold` 0, `param_out` 0, `param_target` 0, `write_param` 0, `err` 0.
- All outputs are registered.
- WRITE frame: NB+1 accepted bytes; the shadow entry updates on the clock edge that accepts the last byte.
- COMMIT latency, with `filter_ready` continuously 1: `hold` rises 1 cycle after the header is accepted. The first `write_param` comes 2 cycles later. Five consecutive strobes follow. `hold` falls in the cycle after the k = 4 strobe.
- If `filter_ready` is 0, HOLD waits indefinitely with no timeout. An in-flight filter computation always completes before the burst begins.
- `in_valid` with `in_ready` = 0 is not a transfer; the byte must be held by the source.
- Back-to-back frames are accepted with no idle cycles between them.

## Configuration
- `BIQUAD_LOADER_CHECKSUM_EN` defined:
  - A WRITE frame carries one extra byte: the XOR of the header and all payload bytes.
  - On a match, the shadow entry updates when the checksum byte is accepted.
  - On a mismatch, the shadow is unchanged and `err` := 1.
  - COMMIT, CLEAR and CLRERR carry no checksum.
- Undefined: no CHECK state; a WRITE frame is exactly NB+1 bytes.

## Test plan
- Reset, then WRITE idx 0 payload 0x40,0x00, then COMMIT, with `filter_ready` = 1 -> five strobes on consecutive cycles: target 0 value 0x4000, targets 1..4 value 0x0000; `hold` is high from one cycle after the COMMIT header until the cycle after the last strobe.
- COMMIT while `filter_ready` = 0 for 20 cycles -> `hold` = 1 and `write_param` = 0 throughout; the first strobe comes 1 cycle after `filter_ready` rises.
- WRITE idx 6 payload 0x12,0x34 -> `err` = 1, shadow unchanged (a following COMMIT writes the prior values); then CLRERR -> `err` = 0.
- Assert `reset` mid-payload (after 1 of 2 bytes) and mid-burst (after strobe k = 2) -> no further strobes, all outputs at reset values, next WRITE frame parses correctly.
- With `BIQUAD_LOADER_CHECKSUM_EN`: WRITE idx 3 payload 0xFF,0x80 with checksum 0x03^0xFF^0x80 = 0x7C -> after COMMIT, a1 is written as 0xFF80; the same frame with checksum 0x00 -> `err` = 1 and a1 unchanged.
- Stall test: random `in_valid` gaps across three back-to-back WRITE frames -> shadow contents match the frames exactly; no byte is lost or duplicated.

Source files
------------

// File: rtl/biquad_coef_loader.sv
// Byte-serial coefficient loader for a biquad: assembles coefficients into a shadow bank and bursts them on COMMIT.
// Optional per-frame XOR checksum on WRITE frames is enabled by defining BIQUAD_LOADER_CHECKSUM_EN.
module biquad_coef_loader #(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  filter_ready,
    output logic                  hold,
    output logic [data_width-1:0] param_out,
    output logic [2:0]            param_target,
    output logic                  write_param,
    output logic                  err
);
    localparam int         NB         = data_width / 8;
    localparam logic [1:0] CNT_LAST   = 2'(NB - 1);
    localparam logic [2:0] IDX_MAX    = 3'd4;
    localparam logic [1:0] CMD_WRITE  = 2'b00;
    localparam logic [1:0] CMD_COMMIT = 2'b01;
    localparam logic [1:0] CMD_CLEAR  = 2'b10;
    localparam logic [1:0] CMD_CLRERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_HOLD    = 3'd2,
`ifdef BIQUAD_LOADER_CHECKSUM_EN
        ST_BURST   = 3'd3,
        ST_CHECK   = 3'd4
`else
        ST_BURST   = 3'd3
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            k_q, k_d;
    logic [data_width-1:0] asm_q, asm_d;
    logic [data_width-1:0] shadow_q [5];
    logic [data_width-1:0] shadow_d [5];
    logic                  hold_q, hold_d, hold_prev_q;
    logic                  in_ready_q, in_ready_d;
    logic                  write_param_q, write_param_d;
    logic                  err_q, err_d;
    logic [data_width-1:0] param_out_q, param_out_d;
    logic [2:0]            param_target_q, param_target_d;
    logic                  xfer_s;
    logic [data_width-1:0] assembled_s;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        csum_step = acc ^ b;
    endfunction
`endif

    function automatic logic [data_width-1:0] shadow_sel(input logic [2:0] k,
                                                         input logic [data_width-1:0] bank [5]);
        case (k)
            3'd0:    shadow_sel = bank[0];
            3'd1:    shadow_sel = bank[1];
            3'd2:    shadow_sel = bank[2];
            3'd3:    shadow_sel = bank[3];
            3'd4:    shadow_sel = bank[4];
            default: shadow_sel = {data_width{1'b0}};
        endcase
    endfunction

    assign xfer_s      = in_valid && in_ready_q;
    assign assembled_s = data_width'({asm_q, in_data});

    // Next-state, shadow bank update and registered-output precomputation
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        k_d            = k_q;
        asm_d          = asm_q;
        shadow_d       = shadow_q;
        err_d          = err_q;
        write_param_d  = 1'b0;
        param_out_d    = param_out_q;
        param_target_d = param_target_q;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    case (in_data[7:6])
                        CMD_WRITE: begin
                            state_d = ST_PAYLOAD;
                            idx_d   = in_data[2:0];
                            cnt_d   = 2'd0;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
                            csum_d  = in_data;
`endif
                        end
                        CMD_COMMIT: state_d = ST_HOLD;
                        CMD_CLEAR: begin
                            for (int i = 0; i < 5; i++) begin
                                shadow_d[i] = {data_width{1'b0}};
                            end
                        end
                        CMD_CLRERR: err_d = 1'b0;
                        default:    state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (xfer_s) begin
                    asm_d = assembled_s;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
                    csum_d = csum_step(csum_q, in_data);
`endif
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = 2'd0;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_IDLE;
                        if (idx_q > IDX_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            for (int i = 0; i < 5; i++) begin
                                shadow_d[i] = (idx_q == 3'(i)) ? assembled_s : shadow_q[i];
                            end
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
`ifdef BIQUAD_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer_s) begin
                    state_d = ST_IDLE;
                    if ((in_data != csum_q) || (idx_q > IDX_MAX)) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < 5; i++) begin
                            shadow_d[i] = (idx_q == 3'(i)) ? asm_q : shadow_q[i];
                        end
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            ST_HOLD: begin
                // hold must have been visible for a full cycle so no start can slip past it
                if (hold_q && hold_prev_q && filter_ready) begin
                    state_d        = ST_BURST;
                    k_d            = 3'd0;
                    write_param_d  = 1'b1;
                    param_target_d = 3'd0;
                    param_out_d    = shadow_q[0];
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_BURST: begin
                if (k_q == IDX_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d            = k_q + 3'd1;
                    write_param_d  = 1'b1;
                    param_target_d = k_d;
                    param_out_d    = shadow_sel(k_d, shadow_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        hold_d     = (state_d == ST_HOLD) || (state_d == ST_BURST);
        in_ready_d = !hold_d;
    end

    // State, shadow bank and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 2'd0;
            idx_q          <= 3'd0;
            k_q            <= 3'd0;
            asm_q          <= {data_width{1'b0}};
            for (int i = 0; i < 5; i++) begin
                shadow_q[i] <= {data_width{1'b0}};
            end
            hold_q         <= 1'b0;
            hold_prev_q    <= 1'b0;
            in_ready_q     <= 1'b1;
            write_param_q  <= 1'b0;
            err_q          <= 1'b0;
            param_out_q    <= {data_width{1'b0}};
            param_target_q <= 3'd0;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
            csum_q         <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            k_q            <= k_d;
            asm_q          <= asm_d;
            shadow_q       <= shadow_d;
            hold_q         <= hold_d;
            hold_prev_q    <= hold_q;
            in_ready_q     <= in_ready_d;
            write_param_q  <= write_param_d;
            err_q          <= err_d;
            param_out_q    <= param_out_d;
            param_target_q <= param_target_d;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign hold         = hold_q;
    assign param_out    = param_out_q;
    assign param_target = param_target_q;
    assign write_param  = write_param_q;
    assign err          = err_q;

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Directed + randomized bench for biquad_coef_loader; expected values come from a shadow-bank model.
module tb_biquad_coef_loader;
    localparam int DW = 16;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          filter_ready;
    logic          hold;
    logic [DW-1:0] param_out;
    logic [2:0]    param_target;
    logic          write_param;
    logic          err;

    logic [DW-1:0] shadow_m [5];
    logic          err_m;
    int            n_checks = 0;
    int            n_fail   = 0;

    biquad_coef_loader #(.data_width(DW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .filter_ready(filter_ready), .hold(hold), .param_out(param_out),
        .param_target(param_target), .write_param(write_param), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic gap(input int max_gap);
        repeat ($urandom_range(0, max_gap)) tick();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) shadow_m[i] = '0;
        err_m = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_hold"}, 32'(hold), 32'd0);
        chk({tag, "_param_out"}, 32'(param_out), 32'd0);
        chk({tag, "_param_target"}, 32'(param_target), 32'd0);
        chk({tag, "_write_param"}, 32'(write_param), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic write_frame(input logic [2:0] idx, input logic [DW-1:0] val, input int max_gap);
        logic [7:0] hdr;
        logic [7:0] b;
        logic [7:0] cs;
        hdr = {2'b00, 3'($urandom), idx};
        cs  = hdr;
        gap(max_gap);
        send_byte(hdr);
        for (int j = 0; j < NB; j++) begin
            b  = val[DW-1-8*j -: 8];
            cs = cs ^ b;
            gap(max_gap);
            send_byte(b);
        end
`ifdef BIQUAD_LOADER_CHECKSUM_EN
        gap(max_gap);
        send_byte(cs);
`endif
        if (idx <= 3'd4) shadow_m[idx] = val;
        else err_m = 1'b1;
        chk("err_after_write", 32'(err), 32'(err_m));
    endtask

    // low: cycles filter_ready stays 0 after the header (0 = always ready); abort_k: strobe after which reset hits
    task automatic commit_check(input int low, input int abort_k);
        filter_ready = (low == 0);
        send_byte(8'h40 | 8'($urandom_range(0, 63)));
        chk("hold_rise", 32'(hold), 32'd1);
        chk("no_strobe_c1", 32'(write_param), 32'd0);
        if (low == 0) begin
            tick();
            chk("hold_c2", 32'(hold), 32'd1);
            chk("no_strobe_c2", 32'(write_param), 32'd0);
            tick();
        end else begin
            for (int i = 1; i < low; i++) begin
                tick();
                chk("hold_wait", 32'(hold), 32'd1);
                chk("no_strobe_wait", 32'(write_param), 32'd0);
            end
            filter_ready = 1'b1;
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            chk("strobe", 32'(write_param), 32'd1);
            chk("target", 32'(param_target), 32'(k));
            chk("value", 32'(param_out), 32'(shadow_m[k]));
            chk("hold_burst", 32'(hold), 32'd1);
            chk("in_ready_burst", 32'(in_ready), 32'd0);
            if (k == abort_k) begin
                pulse_reset();
                check_reset_vals("burst_abort");
                for (int i = 0; i < 6; i++) begin
                    tick();
                    chk("no_strobe_after_reset", 32'(write_param), 32'd0);
                end
                return;
            end
            tick();
        end
        chk("hold_fall", 32'(hold), 32'd0);
        chk("strobe_end", 32'(write_param), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
        chk("err_after_commit", 32'(err), 32'(err_m));
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        filter_ready = 1'b1;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        check_reset_vals("reset");

        // Basic WRITE + COMMIT with the filter always ready
        write_frame(3'd0, 16'h4000, 0);
        commit_check(0, -1);

        // COMMIT held off by a busy filter; shadow persists across commits
        commit_check(20, -1);

        // Out-of-range index: error, bank untouched, then CLRERR
        write_frame(3'd6, 16'h1234, 0);
        chk("err_set", 32'(err), 32'd1);
        commit_check(0, -1);
        send_byte(8'hC0 | 8'($urandom_range(0, 63)));
        err_m = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // CLEAR zeroes the whole bank
        for (int i = 0; i < 5; i++) write_frame(3'(i), 16'($urandom), 0);
        send_byte(8'h80 | 8'($urandom_range(0, 63)));
        for (int i = 0; i < 5; i++) shadow_m[i] = '0;
        commit_check(0, -1);

        // Random stalls across back-to-back frames
        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < 3; f++) write_frame(3'($urandom_range(0, 4)), 16'($urandom), 3);
            commit_check(0, -1);
        end

        // Reset in the middle of a payload
        write_frame(3'd1, 16'hBEEF, 0);
        send_byte(8'h02);
        send_byte(8'hAA);
        pulse_reset();
        check_reset_vals("payload_abort");
        write_frame(3'd2, 16'h5A5A, 0);
        commit_check(0, -1);

        // Reset in the middle of a burst
        for (int i = 0; i < 5; i++) write_frame(3'(i), 16'($urandom), 1);
        commit_check(0, 2);
        write_frame(3'd4, 16'hC3A5, 0);
        commit_check(0, -1);

`ifdef BIQUAD_LOADER_CHECKSUM_EN
        // Checksum-protected frames
        send_byte(8'h03); send_byte(8'hFF); send_byte(8'h80); send_byte(8'h7C);
        shadow_m[3] = 16'hFF80;
        chk("csum_ok_err", 32'(err), 32'd0);
        commit_check(0, -1);
        send_byte(8'h03); send_byte(8'hFF); send_byte(8'h80); send_byte(8'h00);
        err_m = 1'b1;
        chk("csum_bad_err", 32'(err), 32'd1);
        send_byte(8'h03); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        chk("csum_bad_err2", 32'(err), 32'd1);
        commit_check(0, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
